// File: rtl/vsim_indication_arbiter_if.sv
// Portal-side and beat-side signals of the indication arbiter.
// master: arbiter view, slave: portals plus beat sink.
interface vsim_indication_arbiter_if #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = 4
);
  logic [NUM_PORTS*32-1:0] in_first;
  logic [NUM_PORTS-1:0]    in_rdy;
  logic [NUM_PORTS-1:0]    in_deq;
  logic [31:0]             out_beat;
  logic                    out_valid;
  logic                    out_ready;
  logic                    busy;
  logic [IDX_W-1:0]        grant;

  modport master (
    input  in_first, in_rdy, out_ready,
    output in_deq, out_beat, out_valid,
    output busy, grant
  );

  modport slave (
    output in_first, in_rdy, out_ready,
    input  in_deq, out_beat, out_valid,
    input  busy, grant
  );
endinterface

// File: rtl/vsim_indication_arbiter.sv
// Round-robin message arbiter onto the VsimSource beat stream.
// Optional VSIM_ARB_TAG_EN: header bits [31:28] carry the port index.
module vsim_indication_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = 4
) (
  input logic                      CLK,
  input logic                      RST,
  vsim_indication_arbiter_if.master bus
);
  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q;
  logic [15:0]      remaining_q;
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] grant_q;
  logic             out_valid_q;
  logic [31:0]      out_beat_q;

  logic             can_load;
  logic             found;
  logic             g_rdy;
  logic             load;
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] tgt;
  logic [31:0]      sel_word;
  logic [31:0]      g_word;
  logic [31:0]      hdr_word;
  logic [31:0]      load_word;
  logic [15:0]      hdr_left;

  function automatic logic [IDX_W-1:0] wrap_inc(
    input logic [IDX_W-1:0] x
  );
    if (x == IDX_W'(NUM_PORTS - 1)) return '0;
    return x + 1'b1;
  endfunction

  assign can_load = !out_valid_q || bus.out_ready;

  // Closest ready port at or after rr_ptr, modulo NUM_PORTS.
  always_comb begin : scan
    int best;
    int d;
    best     = NUM_PORTS;
    d        = 0;
    found    = 1'b0;
    sel      = '0;
    sel_word = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      d = (i + NUM_PORTS - int'(rr_ptr_q)) % NUM_PORTS;
      if (bus.in_rdy[i] && d < best) begin
        best     = d;
        found    = 1'b1;
        sel      = IDX_W'(i);
        sel_word = bus.in_first[32*i +: 32];
      end
    end
  end

  always_comb begin
    g_rdy  = 1'b0;
    g_word = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_q == IDX_W'(i)) begin
        g_rdy  = bus.in_rdy[i];
        g_word = bus.in_first[32*i +: 32];
      end
    end
  end

  always_comb begin
    hdr_word = sel_word;
`ifdef VSIM_ARB_TAG_EN
    hdr_word[31:28] = 4'(sel);
`endif
  end

  assign hdr_left = (hdr_word[15:0] == 16'd0) ? 16'd0
                  : hdr_word[15:0] - 16'd1;

  always_comb begin
    if (state_q == IDLE) begin
      tgt       = sel;
      load      = found && can_load && !RST;
      load_word = hdr_word;
    end else begin
      tgt       = grant_q;
      load      = g_rdy && can_load && !RST;
      load_word = g_word;
    end
  end

  always_comb begin
    bus.in_deq = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      bus.in_deq[i] = load && (tgt == IDX_W'(i));
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      out_valid_q <= 1'b0;
      out_beat_q  <= '0;
    end else begin
      if (load) begin
        out_valid_q <= 1'b1;
        out_beat_q  <= load_word;
      end else if (can_load) begin
        out_valid_q <= 1'b0;
      end
      if (load && state_q == IDLE) begin
        grant_q     <= sel;
        remaining_q <= hdr_left;
        if (hdr_left == 16'd0) begin
          rr_ptr_q <= wrap_inc(sel);
        end else begin
          state_q <= BUSY;
        end
      end else if (load) begin
        remaining_q <= remaining_q - 16'd1;
        if (remaining_q == 16'd1) begin
          state_q  <= IDLE;
          rr_ptr_q <= wrap_inc(grant_q);
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_beat  = out_beat_q;
  assign bus.busy      = (state_q == BUSY);
  assign bus.grant     = grant_q;
endmodule

// File: doc/vsim_indication_arbiter.md
# vsim_indication_arbiter

Round-robin arbiter that shares the single simulation indication channel (the VsimSource beat stream) among up to 16 indication portals of the Cnoc top. Each portal presents a 32-bit message FIFO head; the arbiter grants one portal per message, using the word count in the header, and forwards words through a one-entry output register. It sits between the portals' `indications_N_message_first/deq` pins and the VsimSource `beat/en_beat` pins in the Vsim top.

## Interface
- `NUM_PORTS`, 4: number of indication portals, 1..16.
- `IDX_W`, 4: width of the grant index. Must be ≥ clog2(NUM_PORTS); 4 covers all legal values.
- `CLK` input 1: single clock; all logic on the rising edge.
- `RST` input 1: synchronous, active-high reset.
- `in_first` input NUM_PORTS*32: head word of each portal; port i occupies bits [32*i+31:32*i].
- `in_rdy` input NUM_PORTS: port i head valid (RDY_first && RDY_deq).
- `in_deq` output NUM_PORTS: one-hot or zero dequeue strobe to the portals; combinational.
- `out_beat` output 32: registered output word.
- `out_valid` output 1: `out_beat` is valid.
- `out_ready` input 1: sink accepts the word; a transfer occurs when `out_valid && out_ready`.
- `busy` output 1: high when the FSM is in BUSY.
- `grant` output IDX_W: index of the current or most recent granted port.

## Operation
- Header word format is `[31:16]` methodId and `[15:0]` total word count including the header. A count of 0 is treated as 1.
- State: FSM {IDLE, BUSY}, a 16-bit `remaining` counter, an IDX_W `rr_ptr`, and the output register (`out_valid`, `out_beat`).
- `can_load = !out_valid || out_ready`.
- IDLE:
  - Scan ports `rr_ptr`, `rr_ptr+1`, …, wrapping modulo NUM_PORTS. Select the first port with `in_rdy`.
  - If a port is selected and `can_load`, assert its `in_deq`, load the header into the output register, and set `grant` to that port.
  - Set `remaining = count-1`.
  - If `remaining == 0`: stay in IDLE and set `rr_ptr = grant+1` (wrapping).
  - Otherwise go to BUSY.
- BUSY:
  - Only `grant` may dequeue.
  - When `in_rdy[grant] && can_load`: deq, load the word, decrement `remaining`.
  - When `remaining` reaches 0: go to IDLE and set `rr_ptr = grant+1` (wrapping).
  - Other ports' `in_rdy` are ignored, so messages are never interleaved.
- When `can_load` is true but no word is loaded, `out_valid` clears in the same edge the held word is accepted.
- Body words pass through unmodified.

## Timing
- Reset values:
  - `out_valid` = 0, `out_beat` = 0, `in_deq` = 0.
  - `busy` = 0, `grant` = 0.
  - `rr_ptr` = 0, `remaining` = 0.
  - FSM = IDLE.
- Latency: a word dequeued in cycle t is visible on `out_beat/out_valid` in cycle t+1.
- Throughput: one word per cycle with `out_ready` held high. There is no bubble between back-to-back messages: the last body word is dequeued in cycle t and the next header in cycle t+1.
- Backpressure: while `out_valid && !out_ready`, `in_deq` = 0 and all state is held.
- Starvation bound: a ready port waits at most NUM_PORTS-1 messages.
- Source stall: if the granted port drops `in_rdy` mid-message, the arbiter stays in BUSY and holds the grant indefinitely.
- Reset mid-message:
  - The next edge with `RST` = 1 returns all state to reset values and discards any output-register word.
  - Portal FIFOs are not flushed; resynchronising them is the upstream's responsibility.
- Simultaneous events: a transfer out and a load in on the same edge is legal and keeps `out_valid` = 1.

## Configuration
- `VSIM_ARB_TAG_EN`:
  - Defined: in the header word only, bits [31:28] are replaced by the granted port index (zero-extended to 4 bits) before it enters the output register. Headers from ports with methodId[15:12] ≠ 0 therefore lose those bits.
  - Undefined: headers pass through unmodified and no tag logic is present.

## Test plan
- Reset, then port 2 offers header 0x0005_0003 followed by 0xA, 0xB, with `out_ready` = 1. Expect `out_beat` 0x00050003, 0xA, 0xB on 3 consecutive cycles starting 1 cycle after the header deq; `busy` high for 2 cycles; then `rr_ptr` = 3.
- All 4 ports ready, each with a 1-word message (count 1), `out_ready` = 1. Expect grant order 0,1,2,3,0,… with one word per cycle.
- Port 0 sends a 4-word message and port 1 is ready throughout. Expect no port-1 word until all 4 port-0 words are out; the port-1 header appears the cycle immediately after.
- `out_ready` = 0 for 5 cycles mid-message. Expect `out_beat` held, `in_deq` = 0, and no words lost or duplicated after release.
- Header with count 0 is treated as a single-word message: arbiter returns to IDLE and the next word on that port is treated as a new header.
- `RST` pulsed during word 2 of a 5-word message. Expect `out_valid` = 0, `busy` = 0, `grant` = 0 the next cycle. With `VSIM_ARB_TAG_EN`, a port-3 header 0x0001_0001 emerges as 0x3001_0001.
